// File: rtl/exu_mdu_seq.sv
// Iterative RV32 M-extension unit. One shared shift/add-subtract datapath
// retires one bit per cycle: shift-add for multiply, restoring division
// for divide. Divide-by-zero and signed overflow finish without iterating.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; o_ready=1
// S_CALC | one datapath iteration per cycle, counter 0..WIDTH-1
// S_DONE | o_valid=1, o_result held until i_ready or i_flush
module exu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             sa_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             s1_signed, s2_signed, sign_a, sign_b, is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             special;
  logic [WIDTH-1:0] special_res;

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state != S_IDLE);

  // Operand decode at accept: signedness, magnitudes and the no-iterate cases.
  always_comb begin
    s1_signed   = (i_op == 3'b000) || (i_op == 3'b001) || (i_op == 3'b010) ||
                  (i_op == 3'b100) || (i_op == 3'b110);
    s2_signed   = (i_op == 3'b000) || (i_op == 3'b001) ||
                  (i_op == 3'b100) || (i_op == 3'b110);
    sign_a      = s1_signed && i_src1[WIDTH-1];
    sign_b      = s2_signed && i_src2[WIDTH-1];
    mag_a       = sign_a ? (~i_src1 + 1'b1) : i_src1;
    mag_b       = sign_b ? (~i_src2 + 1'b1) : i_src2;
    is_div      = i_op[2];
    special     = 1'b0;
    special_res = '0;
    if (is_div && (i_src2 == '0)) begin
      special     = 1'b1;
      special_res = i_op[1] ? i_src1 : {WIDTH{1'b1}};
    end else if (((i_op == 3'b100) || (i_op == 3'b110)) &&
                 (i_src1 == INT_MIN) && (&i_src2)) begin
      special     = 1'b1;
      special_res = i_op[1] ? '0 : INT_MIN;
    end
  end

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   fix_res;

  // One iteration of the shared datapath plus the final sign fixup.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_q});
    diff    = shifted[WIDTH-1:0] - b_q;
    if (op_q[2]) begin
      hi_n = ge ? diff : shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = add_sum[WIDTH:1];
      lo_n = {add_sum[0], lo_q[WIDTH-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quot   = neg_q ? (~lo_n + 1'b1) : lo_n;
    rem    = sa_q ? (~hi_n + 1'b1) : hi_n;
    case (op_q)
      3'b000:                 fix_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  // Sequencer: accept, iterate, hold result until consumed or flushed.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid && !i_flush) begin
            op_q  <= i_op;
            neg_q <= sign_a ^ sign_b;
            sa_q  <= sign_a;
            cnt   <= '0;
            hi_q  <= '0;
            // Multiply: lo holds the multiplier; divide: lo holds the dividend.
            lo_q  <= is_div ? mag_a : mag_b;
            b_q   <= is_div ? mag_b : mag_a;
            if (special) begin
              o_result <= special_res;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              o_result <= fix_res;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (i_flush || i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_mdu_seq.sv
// Directed bench for exu_mdu_seq: results, latency, backpressure, flush, reset.
module tb_exu_mdu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_src1 = '0;
  logic [31:0] i_src2 = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  exu_mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one request, scramble operands after accept, wait for o_valid.
  // cycles = edges from presenting the request to first o_valid (0 = timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int cycles);
    i_ready = 1'b0;
    i_op    = op;
    i_src1  = a;
    i_src2  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_op    = 3'($urandom);
    i_src1  = $urandom;
    i_src2  = $urandom;
    cycles  = 1;
    while (!o_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    if (!o_valid) cycles = 0;
    res = o_result;
  endtask

  task automatic consume();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    n_cmp++;
    if ({o_valid, o_busy, o_ready} !== 3'b001 || o_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: valid/busy/ready=%b result=%h, need 001 00000000",
               {o_valid, o_busy, o_ready}, o_result);
    end
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int          cyc;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, cyc);
    n_cmp++;
    if (res !== 32'hFFFF_FFEB) begin
      n_err++;
      $display("FAIL mul_result: got %h need ffffffeb", res);
    end
    n_cmp++;
    if (cyc !== 33) begin
      n_err++;
      $display("FAIL mul_latency: got %0d need 33", cyc);
    end
    consume();
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int          cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], res, cyc);
      n_cmp++;
      if (res !== exp[i] || cyc !== 33) begin
        n_err++;
        $display("FAIL mulh_%0d: got %h after %0d cycles need %h after 33",
                 i, res, cyc, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
    logic [31:0] res;
    int          cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], 32'd2, res, cyc);
      n_cmp++;
      if (res !== exp[i] || cyc !== 33) begin
        n_err++;
        $display("FAIL div_%0d: got %h after %0d cycles need %h after 33",
                 i, res, cyc, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int          cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, cyc);
      n_cmp++;
      if (res !== exp[i] || cyc !== 1) begin
        n_err++;
        $display("FAIL special_%0d: got %h after %0d cycles need %h after 1",
                 i, res, cyc, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          cyc;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cyc);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({o_valid, o_ready} !== 2'b10 || o_result !== 32'hFFFF_FFFE) begin
        n_err++;
        $display("FAIL hold_%0d: valid/ready=%b result=%h need 10 fffffffe",
                 i, {o_valid, o_ready}, o_result);
      end
    end
    i_op    = 3'b100;
    i_src1  = 32'd5;
    i_src2  = 32'd0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_cmp++;
    if ({o_valid, o_ready, o_busy} !== 3'b010) begin
      n_err++;
      $display("FAIL release_idle: valid/ready/busy=%b need 010",
               {o_valid, o_ready, o_busy});
    end
    tick();
    i_valid = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL next_accept: valid=%b result=%h need 1 ffffffff",
               o_valid, o_result);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          cyc;
    bit          saw_valid = 1'b0;
    // flush presented with a request in IDLE blocks the accept
    i_op    = 3'b101;
    i_src1  = 32'd9;
    i_src2  = 32'd4;
    i_valid = 1'b1;
    i_flush = 1'b1;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    n_cmp++;
    if ({o_ready, o_busy, o_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL flush_idle: ready/busy/valid=%b need 100",
               {o_ready, o_busy, o_valid});
    end
    // flush with the iteration counter at 10
    i_op    = 3'b000;
    i_src1  = 32'd3;
    i_src2  = 32'd4;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_valid) saw_valid = 1'b1;
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++;
    if ({o_ready, o_busy, o_valid} !== 3'b100 || o_result !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL flush_calc: ready/busy/valid=%b result=%h need 100 ffffffff",
               {o_ready, o_busy, o_valid}, o_result);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_valid) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_valid: o_valid seen=%b need 0", saw_valid);
    end
    // flush while holding a result in DONE
    run_op(3'b110, 32'd5, 32'd0, res, cyc);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01 || o_result !== 32'd5) begin
      n_err++;
      $display("FAIL flush_done: valid/ready=%b result=%h need 01 00000005",
               {o_valid, o_ready}, o_result);
    end
  endtask

  task automatic test_reset_mid_calc();
    i_op    = 3'b000;
    i_src1  = 32'd11;
    i_src2  = 32'd13;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL calc_busy: busy=%b need 1", o_busy);
    end
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    n_cmp++;
    if ({o_valid, o_busy, o_ready} !== 3'b001 || o_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_calc: valid/busy/ready=%b result=%h need 001 00000000",
               {o_valid, o_busy, o_ready}, o_result);
    end
    repeat (40) tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_valid: valid=%b need 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
